// File: rtl/sig_result_collector_pkg.sv
// Shared types and widths for the result collector: FSM states, sample width
// and the window-sum width helper.
package sig_collect_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic {
        FILL    = 1'b0,
        PUBLISH = 1'b1
    } state_t;

    function automatic int sum_width(input int win_log2);
        return SAMPLE_W + win_log2;
    endfunction

endpackage

// File: rtl/sig_result_collector_if.sv
// Sample input and valid/ready output bus of the result collector.
// The slave modport is the collector's view; master is the host/consumer view.
interface sig_result_collector_if;
    import sig_collect_pkg::*;

    logic [SAMPLE_W-1:0] result_in;
    logic                result_valid;
    logic [SAMPLE_W-1:0] out_data;
    logic                out_valid;
    logic                out_ready;

    modport slave (
        input  result_in,
        input  result_valid,
        input  out_ready,
        output out_data,
        output out_valid
    );

    modport master (
        output result_in,
        output result_valid,
        output out_ready,
        input  out_data,
        input  out_valid
    );

endinterface

// File: rtl/sig_result_collector_fifo.sv
// Synchronous FIFO with a registered head word, so the oldest entry is
// presented straight from a flop and holds its value once the FIFO drains.
module sig_result_fifo
    import sig_collect_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [SAMPLE_W-1:0] data_i,
    output logic [SAMPLE_W-1:0] head_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CW-1:0]       count_o
);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       rd_inc;
    logic [CW-1:0]       count_q, count_d;
    logic [SAMPLE_W-1:0] head_q, head_d;
    logic                full, empty, push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop_i & ~empty;
    assign push_ok = push_i & (~full | pop_ok);
    assign rd_inc  = rd_ptr_q + AW'(1);

    always_ff @(posedge clk) begin
        if (push_ok && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // The head register tracks mem_q[rd_ptr_q] one step ahead; when the popped
    // entry is the last one, an incoming word bypasses straight to the head.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_inc;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - CW'(1);
            end
            if (pop_ok) begin
                if (count_q > CW'(1)) begin
                    head_d = mem_q[rd_inc];
                end else if (push_ok) begin
                    head_d = data_i;
                end
            end else if (push_ok && empty) begin
                head_d = data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_o  = head_q;
    assign full_o  = full;
    assign empty_o = empty;
    assign count_o = count_q;

endmodule

// File: rtl/sig_result_collector.sv
// Result collector: buffers host results in a FIFO and publishes average,
// minimum and maximum over fixed windows of 2**WIN_LOG2 samples.
module sig_result_collector
    import sig_collect_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WIN_LOG2 = 3,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    sig_result_collector_if.slave bus,
    output logic [CW-1:0]         fifo_count_o,
    output logic                  overflow_o,
    output logic [SAMPLE_W-1:0]   win_avg_o,
    output logic [SAMPLE_W-1:0]   win_min_o,
    output logic [SAMPLE_W-1:0]   win_max_o,
    output logic                  win_done_o
);

    localparam int SUM_W = sum_width(WIN_LOG2);
    localparam logic [WIN_LOG2-1:0] IDX_LAST = '1;

    logic                full, empty, push, pop, sample;
    logic [SAMPLE_W-1:0] head;
    logic                overflow_q, overflow_d;

    assign pop    = ~empty & bus.out_ready;
    assign push   = bus.result_valid & (~full | pop);
    assign sample = bus.result_valid & ~clear_i;

    sig_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (bus.result_in),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count_o)
    );

    assign bus.out_data  = head;
    assign bus.out_valid = ~empty;

    always_comb begin
        overflow_d = overflow_q;
        if (clear_i) begin
            overflow_d = 1'b0;
        end else if (bus.result_valid && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    state_t              state_q, state_d;
    logic [SUM_W-1:0]    sum_q, sum_d, sum_next;
    logic [WIN_LOG2-1:0] idx_q, idx_d;
    logic [SAMPLE_W-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
    logic [SAMPLE_W-1:0] samp_min, samp_max;
    logic [SAMPLE_W-1:0] win_avg_q, win_avg_d, win_min_q, win_min_d;
    logic [SAMPLE_W-1:0] win_max_q, win_max_d;
    logic                win_done_q, win_done_d;

    // Index 0 marks the first sample of a window, which seeds min and max.
    assign sum_next = sum_q + {{WIN_LOG2{1'b0}}, bus.result_in};
    assign samp_min = (idx_q == '0 || bus.result_in < run_min_q) ? bus.result_in : run_min_q;
    assign samp_max = (idx_q == '0 || bus.result_in > run_max_q) ? bus.result_in : run_max_q;

    // Results are latched on the edge that registers the final sample, so the
    // PUBLISH cycle shows them alongside win_done and is free to start a window.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        run_min_d  = run_min_q;
        run_max_d  = run_max_q;
        win_avg_d  = win_avg_q;
        win_min_d  = win_min_q;
        win_max_d  = win_max_q;
        win_done_d = 1'b0;
        if (clear_i) begin
            state_d = FILL;
            sum_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (sample) begin
                        sum_d     = sum_next;
                        idx_d     = idx_q + WIN_LOG2'(1);
                        run_min_d = samp_min;
                        run_max_d = samp_max;
                        if (idx_q == IDX_LAST) begin
                            state_d    = PUBLISH;
                            win_avg_d  = sum_next[SUM_W-1:WIN_LOG2];
                            win_min_d  = samp_min;
                            win_max_d  = samp_max;
                            win_done_d = 1'b1;
                            sum_d      = '0;
                            idx_d      = '0;
                        end
                    end
                end
                PUBLISH: begin
                    state_d = FILL;
                    if (sample) begin
                        sum_d     = sum_next;
                        idx_d     = idx_q + WIN_LOG2'(1);
                        run_min_d = samp_min;
                        run_max_d = samp_max;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            sum_q      <= '0;
            idx_q      <= '0;
            run_min_q  <= '0;
            run_max_q  <= '0;
            win_avg_q  <= '0;
            win_min_q  <= '0;
            win_max_q  <= '0;
            win_done_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            run_min_q  <= run_min_d;
            run_max_q  <= run_max_d;
            win_avg_q  <= win_avg_d;
            win_min_q  <= win_min_d;
            win_max_q  <= win_max_d;
            win_done_q <= win_done_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;
    assign win_avg_o  = win_avg_q;
    assign win_min_o  = win_min_q;
    assign win_max_o  = win_max_q;
    assign win_done_o = win_done_q;

endmodule

// File: tb/tb_sig_result_collector.sv
// Directed bench for sig_result_collector: a queue scoreboard for the FIFO
// path and a reference window model for the statistics outputs.
module tb_sig_result_collector;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [3:0]  fifo_count;
    logic        overflow, win_done;
    logic [15:0] win_avg, win_min, win_max;

    sig_result_collector_if bus();

    sig_result_collector #(.DEPTH(DEPTH), .WIN_LOG2(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear),
        .bus          (bus.slave),
        .fifo_count_o (fifo_count),
        .overflow_o   (overflow),
        .win_avg_o    (win_avg),
        .win_min_o    (win_min),
        .win_max_o    (win_max),
        .win_done_o   (win_done)
    );

    always #5 clk = ~clk;

    logic [15:0] sb[$];
    int          checks = 0;
    int          errors = 0;
    bit          ovf_m, done_m;
    int          wcnt;
    int unsigned wsum;
    logic [15:0] wmin_m, wmax_m, avg_h, min_h, max_h;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("fifo_count", {28'd0, fifo_count}, sb.size());
        checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, sb.size() != 0});
        checkOutput("overflow", {31'd0, overflow}, {31'd0, ovf_m});
        checkOutput("win_done", {31'd0, win_done}, {31'd0, done_m});
        checkOutput("win_avg", {16'd0, win_avg}, {16'd0, avg_h});
        checkOutput("win_min", {16'd0, win_min}, {16'd0, min_h});
        checkOutput("win_max", {16'd0, win_max}, {16'd0, max_h});
    endtask

    task automatic modelReset();
        sb.delete();
        ovf_m  = 1'b0;
        done_m = 1'b0;
        wcnt   = 0;
        wsum   = 0;
        avg_h  = '0;
        min_h  = '0;
        max_h  = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_out_data"}, {16'd0, bus.out_data}, 32'd0);
        checkOutput({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        checkOutput({tag, "_fifo_count"}, {28'd0, fifo_count}, 32'd0);
        checkOutput({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        checkOutput({tag, "_win_avg"}, {16'd0, win_avg}, 32'd0);
        checkOutput({tag, "_win_min"}, {16'd0, win_min}, 32'd0);
        checkOutput({tag, "_win_max"}, {16'd0, win_max}, 32'd0);
        checkOutput({tag, "_win_done"}, {31'd0, win_done}, 32'd0);
    endtask

    // One clock cycle: drive inputs, check current outputs, advance the model.
    task automatic applyStimulus(input bit v, input logic [15:0] d, input bit rdy, input bit clr);
        bit          pop_m, full_m;
        logic [15:0] exp_head;
        bus.result_valid = v;
        bus.result_in    = d;
        bus.out_ready    = rdy;
        clear            = clr;
        #1;
        checkAll();
        full_m = (sb.size() == DEPTH);
        pop_m  = (sb.size() != 0) && rdy && !clr;
        if (clr) begin
            sb.delete();
            ovf_m  = 1'b0;
            done_m = 1'b0;
            wcnt   = 0;
        end else begin
            done_m = 1'b0;
            if (pop_m) begin
                exp_head = sb.pop_front();
                checkOutput("drain_data", {16'd0, bus.out_data}, {16'd0, exp_head});
            end
            if (v) begin
                if (!full_m || pop_m) sb.push_back(d);
                else ovf_m = 1'b1;
                if (wcnt == 0) begin
                    wsum   = 0;
                    wmin_m = d;
                    wmax_m = d;
                end else begin
                    if (d < wmin_m) wmin_m = d;
                    if (d > wmax_m) wmax_m = d;
                end
                wsum += d;
                wcnt++;
                if (wcnt == 8) begin
                    avg_h  = 16'(wsum / 8);
                    min_h  = wmin_m;
                    max_h  = wmax_m;
                    done_m = 1'b1;
                    wcnt   = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, rdy, 1'b0);
    endtask

    initial begin
        bus.result_valid = 1'b0;
        bus.result_in    = '0;
        bus.out_ready    = 1'b0;
        modelReset();
        #1;
        checkResetOutputs("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(2, 1'b0);

        // Window of 1..8, one sample every 4 cycles, consumer always ready
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b1, 1'b0);
            idle(3, 1'b1);
        end
        checkOutput("win_avg_1to8", {16'd0, win_avg}, 32'd4);
        checkOutput("win_min_1to8", {16'd0, win_min}, 32'd1);
        checkOutput("win_max_1to8", {16'd0, win_max}, 32'd8);

        // Overflow: nine pushes into a blocked FIFO, then drain
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        checkOutput("ovf_count_full", {28'd0, fifo_count}, 32'd8);
        checkOutput("ovf_flag_set", {31'd0, overflow}, 32'd1);
        idle(10, 1'b1);
        checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
        checkOutput("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO with a simultaneous push and pop
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0208, 1'b1, 1'b0);
        checkOutput("fullpp_count", {28'd0, fifo_count}, 32'd8);
        checkOutput("fullpp_overflow", {31'd0, overflow}, 32'd0);
        idle(10, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);

        // Back-to-back windows: 0xFFFF x8 then a sample in the PUBLISH cycle
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
        checkOutput("b2b_done", {31'd0, win_done}, 32'd1);
        checkOutput("b2b_avg", {16'd0, win_avg}, 32'hFFFF);
        checkOutput("b2b_min", {16'd0, win_min}, 32'hFFFF);
        checkOutput("b2b_max", {16'd0, win_max}, 32'hFFFF);
        applyStimulus(1'b1, 16'h0002, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'd9, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'd7, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'd4, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'd6, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'd8, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'd10, 1'b1, 1'b0);
        checkOutput("win2_avg", {16'd0, win_avg}, 32'd6);
        checkOutput("win2_min", {16'd0, win_min}, 32'd2);
        checkOutput("win2_max", {16'd0, win_max}, 32'd10);
        idle(4, 1'b1);

        // clear colliding with a sample while five entries are queued
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0305, 1'b0, 1'b1);
        checkOutput("clr_count", {28'd0, fifo_count}, 32'd0);
        checkOutput("clr_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("clr_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("clr_hold_avg", {16'd0, win_avg}, 32'd6);
        checkOutput("clr_hold_min", {16'd0, win_min}, 32'd2);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'h0010 + 16'(i), 1'b1, 1'b0);
        idle(2, 1'b1);
        checkOutput("post_clr_avg", {16'd0, win_avg}, 32'h13);

        // Asynchronous reset with three entries queued mid-window
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0400 + 16'(i), 1'b0, 1'b0);
        bus.result_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkResetOutputs("midrst");
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        idle(3, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'h0020 + 16'(i), 1'b1, 1'b0);
        idle(3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
